mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single 256-bit line-wide data-memory port between the instruction cache and the data cache. It sits between both cache controllers and the memory model. It latches the winning request, drives it to memory until acknowledge, and returns a registered acknowledge pulse with held read data to the winner only.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction/data cache memory arbiter:
// FSM state encoding, owner identifiers and default widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick
// Combinational winner select between the icache and dcache requests.
// Build option: MEM_ARBITER_RR_EN selects round-robin tie breaking using
// the pointer input; without it the dcache wins every tie and there is no
// pointer input at all.
// Ports:
//   ptr_i          preferred side on a tie (round-robin build only)
//   ic_enable_i    icache request
//   dc_enable_i    dcache request
//   grant_valid_o  at least one request present
//   grant_dc_o     winner is the dcache (meaningful with grant_valid_o)
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
    input  logic ptr_i,
`endif
    input  logic ic_enable_i,
    input  logic dc_enable_i,
    output logic grant_valid_o,
    output logic grant_dc_o
);

    always_comb begin
        grant_valid_o = ic_enable_i | dc_enable_i;
`ifdef MEM_ARBITER_RR_EN
        // A lone requester wins; on a tie the pointer's side wins.
        grant_dc_o = dc_enable_i & (~ic_enable_i | (ptr_i == OWNER_DC));
`else
        // Fixed priority: any dcache request beats the icache.
        grant_dc_o = dc_enable_i;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one line-wide memory port between the icache and dcache. The
// winning request is latched in IDLE, driven to memory while BUSY, and a
// one-cycle acknowledge (with held read data) is returned to the winner in
// RESP. Build option MEM_ARBITER_RR_EN enables round-robin tie breaking;
// the default build gives the dcache fixed priority.
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   ic_/dc_enable_i              level request, held until ack
//   ic_/dc_write_i               request is a line write
//   ic_/dc_addr_i, ic_/dc_data_i request address / write line
//   ic_/dc_data_o                last read line, held
//   ic_/dc_ack_o                 one-cycle completion pulse to the owner
//   mem_enable_o .. mem_data_o   memory request, driven from the latches
//   mem_data_i, mem_ack_i        memory read line and completion
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_enable_i,
    input  logic              ic_write_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic [LINE_W-1:0] ic_data_i,
    output logic [LINE_W-1:0] ic_data_o,
    output logic              ic_ack_o,
    input  logic              dc_enable_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_data_i,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              dc_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_t        state, state_nxt;
    logic              owner;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_data;
    logic [LINE_W-1:0] ic_rdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              grant_valid;
    logic              grant_dc;
    logic              grant;
    logic              mem_done;

    assign grant    = (state == ARB_IDLE) && grant_valid;
    assign mem_done = (state == ARB_BUSY) && mem_ack_i;

`ifdef MEM_ARBITER_RR_EN
    logic ptr;

    // Hand the next tie to whoever did not just get served.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr <= OWNER_IC;
        end else if (mem_done) begin
            ptr <= ~owner;
        end
    end
`endif

    mem_arbiter_pick u_pick (
`ifdef MEM_ARBITER_RR_EN
        .ptr_i         (ptr),
`endif
        .ic_enable_i   (ic_enable_i),
        .dc_enable_i   (dc_enable_i),
        .grant_valid_o (grant_valid),
        .grant_dc_o    (grant_dc)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant_valid) state_nxt = ARB_BUSY;
            ARB_BUSY: if (mem_ack_i)   state_nxt = ARB_RESP;
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // FSM outputs: request only while BUSY, ack only to the owner in RESP
    always_comb begin
        mem_enable_o = (state == ARB_BUSY);
        ic_ack_o     = (state == ARB_RESP) && (owner == OWNER_IC);
        dc_ack_o     = (state == ARB_RESP) && (owner == OWNER_DC);
    end

    // Request latches: requester inputs are only looked at on the grant edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner     <= OWNER_IC;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
        end else if (grant) begin
            owner     <= grant_dc ? OWNER_DC : OWNER_IC;
            req_write <= grant_dc ? dc_write_i : ic_write_i;
            req_addr  <= grant_dc ? dc_addr_i  : ic_addr_i;
            req_data  <= grant_dc ? dc_data_i  : ic_data_i;
        end
    end

    // Read registers: only the owner's line is updated, and only on reads
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ic_rdata <= '0;
            dc_rdata <= '0;
        end else if (mem_done && !req_write) begin
            if (owner == OWNER_DC) begin
                dc_rdata <= mem_data_i;
            end else begin
                ic_rdata <= mem_data_i;
            end
        end
    end

    assign mem_write_o = req_write;
    assign mem_addr_o  = req_addr;
    assign mem_data_o  = req_data;
    assign ic_data_o   = ic_rdata;
    assign dc_data_o   = dc_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ic_enable_i, ic_write_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic [LINE_W-1:0] ic_data_i, ic_data_o;
    logic              ic_ack_o;
    logic              dc_enable_i, dc_write_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_data_i, dc_data_o;
    logic              dc_ack_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    int checks   = 0;
    int failures = 0;

    logic [LINE_W-1:0] exp_ic_data;
    logic [LINE_W-1:0] exp_dc_data;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] wline;
    logic              first_dc;
    logic              exp_dc;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ic_enable_i  (ic_enable_i),
        .ic_write_i   (ic_write_i),
        .ic_addr_i    (ic_addr_i),
        .ic_data_i    (ic_data_i),
        .ic_data_o    (ic_data_o),
        .ic_ack_o     (ic_ack_o),
        .dc_enable_i  (dc_enable_i),
        .dc_write_i   (dc_write_i),
        .dc_addr_i    (dc_addr_i),
        .dc_data_i    (dc_data_i),
        .dc_data_o    (dc_data_o),
        .dc_ack_o     (dc_ack_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [ADDR_W-1:0] obs,
                            input logic [ADDR_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs,
                            input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One memory completion cycle: ack presented for exactly one edge.
    task automatic ack_mem(input logic [LINE_W-1:0] d);
        mem_data_i = d;
        mem_ack_i  = 1'b1;
        cyc();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    initial begin
        rst_i = 1'b0;
        ic_enable_i = 1'b0; ic_write_i = 1'b0; ic_addr_i = '0; ic_data_i = '0;
        dc_enable_i = 1'b0; dc_write_i = 1'b0; dc_addr_i = '0; dc_data_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        exp_ic_data = '0;
        exp_dc_data = '0;
        first_dc = RR_BUILD ? 1'b0 : 1'b1;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        chk_bit ("rst_mem_enable", mem_enable_o, 1'b0);
        chk_bit ("rst_mem_write",  mem_write_o,  1'b0);
        chk_addr("rst_mem_addr",   mem_addr_o,   '0);
        chk_line("rst_mem_data",   mem_data_o,   '0);
        chk_bit ("rst_ic_ack",     ic_ack_o,     1'b0);
        chk_bit ("rst_dc_ack",     dc_ack_o,     1'b0);
        chk_line("rst_ic_data",    ic_data_o,    '0);
        chk_line("rst_dc_data",    dc_data_o,    '0);
        rst_i = 1'b1;
        cyc();

        // ---------------- lone dc read ----------------
        dc_enable_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 32'h0000_0420;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk_bit ("t1_busy_enable", mem_enable_o, 1'b1);
            chk_addr("t1_busy_addr",   mem_addr_o,   32'h0000_0420);
            chk_bit ("t1_busy_write",  mem_write_o,  1'b0);
            chk_bit ("t1_busy_ic_ack", ic_ack_o,     1'b0);
            chk_bit ("t1_busy_dc_ack", dc_ack_o,     1'b0);
            if (i < 9) cyc();
        end
        line = {32{8'hA5}};
        ack_mem(line);
        exp_dc_data = line;
        chk_bit ("t1_dc_ack",      dc_ack_o,     1'b1);
        chk_bit ("t1_ic_ack",      ic_ack_o,     1'b0);
        chk_line("t1_dc_data",     dc_data_o,    exp_dc_data);
        chk_bit ("t1_resp_enable", mem_enable_o, 1'b0);
        dc_enable_i = 1'b0;
        cyc();
        chk_bit ("t1_dc_ack_once", dc_ack_o,     1'b0);
        chk_line("t1_dc_data_hold", dc_data_o,   exp_dc_data);
        chk_line("t1_ic_data_untouched", ic_data_o, exp_ic_data);

        // ---------------- simultaneous requests ----------------
        ic_enable_i = 1'b1; ic_write_i = 1'b0; ic_addr_i = 32'h0000_0100;
        dc_enable_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 32'h0000_0200;
        cyc();
        chk_bit ("t2_first_enable", mem_enable_o, 1'b1);
        chk_addr("t2_first_addr", mem_addr_o, first_dc ? 32'h0000_0200 : 32'h0000_0100);
        line = {8{32'h1111_0001}};
        ack_mem(line);
        if (first_dc) exp_dc_data = line; else exp_ic_data = line;
        chk_bit ("t2_first_ic_ack", ic_ack_o, ~first_dc);
        chk_bit ("t2_first_dc_ack", dc_ack_o, first_dc);
        chk_line("t2_first_ic_data", ic_data_o, exp_ic_data);
        chk_line("t2_first_dc_data", dc_data_o, exp_dc_data);
        if (first_dc) dc_enable_i = 1'b0; else ic_enable_i = 1'b0;
        cyc();
        chk_bit ("t2_idle_enable", mem_enable_o, 1'b0);
        cyc();
        chk_bit ("t2_second_enable", mem_enable_o, 1'b1);
        chk_addr("t2_second_addr", mem_addr_o, first_dc ? 32'h0000_0100 : 32'h0000_0200);
        line = {8{32'h2222_0002}};
        ack_mem(line);
        if (first_dc) exp_ic_data = line; else exp_dc_data = line;
        chk_bit ("t2_second_ic_ack", ic_ack_o, first_dc);
        chk_bit ("t2_second_dc_ack", dc_ack_o, ~first_dc);
        chk_line("t2_second_ic_data", ic_data_o, exp_ic_data);
        chk_line("t2_second_dc_data", dc_data_o, exp_dc_data);
        ic_enable_i = 1'b0; dc_enable_i = 1'b0;
        cyc();

        // ---------------- dc write, inputs change while BUSY ----------------
        wline = {8{32'h1234_5678}};
        dc_enable_i = 1'b1; dc_write_i = 1'b1; dc_addr_i = 32'h0000_0040; dc_data_i = wline;
        cyc();
        chk_bit ("t3_write",   mem_write_o, 1'b1);
        chk_addr("t3_addr",    mem_addr_o,  32'h0000_0040);
        chk_line("t3_wdata",   mem_data_o,  wline);
        dc_write_i = 1'b0; dc_addr_i = 32'h0000_0080; dc_data_i = {8{32'hDEAD_BEEF}};
        cyc();
        chk_bit ("t3_write_held", mem_write_o, 1'b1);
        chk_addr("t3_addr_held",  mem_addr_o,  32'h0000_0040);
        chk_line("t3_wdata_held", mem_data_o,  wline);
        ack_mem({LINE_W{1'b1}});
        chk_bit ("t3_dc_ack",     dc_ack_o,  1'b1);
        chk_line("t3_dc_data_kept", dc_data_o, exp_dc_data);
        chk_line("t3_ic_data_kept", ic_data_o, exp_ic_data);
        dc_enable_i = 1'b0;
        cyc();

        // ---------------- memory ack outside BUSY ----------------
        ack_mem({32{8'h5A}});
        chk_bit ("t4_stray_ic_ack", ic_ack_o, 1'b0);
        chk_bit ("t4_stray_dc_ack", dc_ack_o, 1'b0);
        chk_bit ("t4_stray_enable", mem_enable_o, 1'b0);
        chk_line("t4_stray_ic_data", ic_data_o, exp_ic_data);
        chk_line("t4_stray_dc_data", dc_data_o, exp_dc_data);
        cyc();

        // ---------------- continuous contention, 4 transactions ----------------
        ic_enable_i = 1'b1; ic_write_i = 1'b0; ic_addr_i = 32'h0000_0300;
        dc_enable_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 32'h0000_0500;
        for (int i = 0; i < 4; i++) begin
            exp_dc = RR_BUILD ? ((i % 2) == 1) : 1'b1;
            cyc();
            chk_bit ("t5_enable", mem_enable_o, 1'b1);
            chk_addr("t5_addr", mem_addr_o, exp_dc ? 32'h0000_0500 : 32'h0000_0300);
            line = {8{32'hC0DE_0000 + i}};
            ack_mem(line);
            if (exp_dc) exp_dc_data = line; else exp_ic_data = line;
            chk_bit ("t5_ic_ack", ic_ack_o, ~exp_dc);
            chk_bit ("t5_dc_ack", dc_ack_o, exp_dc);
            chk_line("t5_ic_data", ic_data_o, exp_ic_data);
            chk_line("t5_dc_data", dc_data_o, exp_dc_data);
            cyc();
            chk_bit ("t5_idle", mem_enable_o, 1'b0);
        end
        ic_enable_i = 1'b0; dc_enable_i = 1'b0;
        cyc();

        // ---------------- reset while BUSY ----------------
        ic_enable_i = 1'b1; ic_write_i = 1'b0; ic_addr_i = 32'h0000_0600;
        cyc();
        chk_bit ("t6_busy", mem_enable_o, 1'b1);
        cyc();
        #2;
        rst_i = 1'b0;
        #1;
        exp_ic_data = '0;
        exp_dc_data = '0;
        chk_bit ("t6_async_enable", mem_enable_o, 1'b0);
        chk_addr("t6_async_addr",   mem_addr_o,   '0);
        chk_bit ("t6_async_write",  mem_write_o,  1'b0);
        chk_line("t6_async_mdata",  mem_data_o,   '0);
        chk_line("t6_async_ic_data", ic_data_o,   '0);
        chk_line("t6_async_dc_data", dc_data_o,   '0);
        cyc();
        chk_bit ("t6_rst_ic_ack", ic_ack_o, 1'b0);
        chk_bit ("t6_rst_dc_ack", dc_ack_o, 1'b0);
        rst_i = 1'b1;
        cyc();
        chk_bit ("t6_regrant", mem_enable_o, 1'b1);
        chk_addr("t6_regrant_addr", mem_addr_o, 32'h0000_0600);
        line = {8{32'h6666_0006}};
        ack_mem(line);
        exp_ic_data = line;
        chk_bit ("t6_ic_ack", ic_ack_o, 1'b1);
        chk_line("t6_ic_data", ic_data_o, exp_ic_data);
        ic_enable_i = 1'b0;
        cyc();

        // ---------------- enable dropped while BUSY ----------------
        dc_enable_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 32'h0000_0700;
        cyc();
        dc_enable_i = 1'b0;
        cyc();
        chk_bit ("t7_still_busy", mem_enable_o, 1'b1);
        cyc();
        chk_addr("t7_addr", mem_addr_o, 32'h0000_0700);
        line = {8{32'h7777_0007}};
        ack_mem(line);
        exp_dc_data = line;
        chk_bit ("t7_dc_ack", dc_ack_o, 1'b1);
        chk_line("t7_dc_data", dc_data_o, exp_dc_data);
        cyc();
        chk_bit ("t7_dc_ack_once", dc_ack_o, 1'b0);
        cyc();
        chk_bit ("t7_no_regrant", mem_enable_o, 1'b0);
        chk_line("t7_ic_data_kept", ic_data_o, exp_ic_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
